// File: rtl/accum_pkg.sv
// Shared widths, lane type, FSM states and write-pipe stage record for the
// accumulator zone.
package accum_pkg;

  localparam int NUM_BANKS_DEF  = 4;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;
  localparam int ZONE_WIDTH_DEF = 2;

  // One beat: one word per bank, bank 0 in the least significant slot.
  typedef logic [NUM_BANKS_DEF-1:0][DATA_WIDTH_DEF-1:0] lane_t;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } zone_state_e;

  // One slot of the write (read-modify-write) pipeline.
  typedef struct packed {
    logic                      valid;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [NUM_BANKS_DEF-1:0]  mask;
    logic                      accum_en;
    lane_t                     data;
  } wr_stage_t;

endpackage

// File: rtl/Accum_Cmd_If.sv
// Command channel between the accumulator router and one zone.
interface Accum_Cmd_If
  import accum_pkg::*;
#(
  parameter int NUM_BANKS  = NUM_BANKS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int ZONE_WIDTH = ZONE_WIDTH_DEF
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  accum_en;
  logic [NUM_BANKS-1:0]  wr_mask;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ZONE_WIDTH-1:0] wr_zone_id;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [NUM_BANKS-1:0]  rd_mask;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ZONE_WIDTH-1:0] rd_zone_id;

  modport Slave (
    input  wr_valid, accum_en, wr_mask, wr_addr, wr_zone_id,
    input  rd_valid, rd_mask, rd_addr, rd_zone_id,
    output wr_ready, rd_ready
  );

  modport Master (
    output wr_valid, accum_en, wr_mask, wr_addr, wr_zone_id,
    output rd_valid, rd_mask, rd_addr, rd_zone_id,
    input  wr_ready, rd_ready
  );
endinterface

// File: rtl/Accum_Data_If.sv
// Data channel between the accumulator router and one zone.
interface Accum_Data_If
  import accum_pkg::*;
#(
  parameter int NUM_BANKS  = NUM_BANKS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                                 wvalid;
  logic                                 wready;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] wdata;
  logic                                 rvalid;
  logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] rdata;

  modport Slave (
    input  wvalid, wdata,
    output wready, rvalid, rdata
  );

  modport Master (
    output wvalid, wdata,
    input  wready, rvalid, rdata
  );
endinterface

// File: rtl/accum_bank.sv
// One bank of the zone: register array with two combinational read ports
// (RMW side and host side) and one clocked write port.
module accum_bank
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] rmw_addr,
  output logic [DATA_WIDTH-1:0] rmw_data,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  output logic [DATA_WIDTH-1:0] host_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Single write port; contents are zeroed by the owner's clear sweep, not by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rmw_data  = mem[rmw_addr];
  assign host_data = mem[host_addr];

endmodule

// File: rtl/accum_zone.sv
// Accumulator zone endpoint: NUM_BANKS banks with masked accumulate/overwrite
// writes through a two-stage RMW pipe, fixed-latency masked reads, and a
// full-zone zero sweep after reset or on clr_req.
module accum_zone
  import accum_pkg::*;
#(
  parameter int NUM_BANKS  = NUM_BANKS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  Accum_Cmd_If.Slave  s_cmd,
  Accum_Data_If.Slave s_data,
  input  logic        clr_req,
  output logic        clr_busy
);

  typedef logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] beat_t;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  zone_state_e           state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  logic                  clear_active;
  logic                  run_ready;
  logic                  wr_fire;
  logic                  rd_fire;

  // ---------------------------------------------------------------------------
  // Pipelines
  // ---------------------------------------------------------------------------
  wr_stage_t             s1_reg, s1_next;
  wr_stage_t             s2_reg, s2_next;
  logic                  r1_valid_reg;
  logic [ADDR_WIDTH-1:0] r1_addr_reg;
  logic [NUM_BANKS-1:0]  r1_mask_reg;
  logic                  rvalid_reg;
  beat_t                 rdata_reg;

  // Per-bank datapath
  beat_t                 rmw_rd;
  beat_t                 rmw_old;
  beat_t                 rmw_new;
  beat_t                 host_rd;
  beat_t                 host_val;
  beat_t                 rd_lane;
  logic [NUM_BANKS-1:0]  bank_we;
  beat_t                 bank_wdata;
  logic [ADDR_WIDTH-1:0] bank_waddr;

  // Zone IDs are already resolved by the router upstream.
  logic unused_zone_ids;
  assign unused_zone_ids = ^{s_cmd.wr_zone_id, s_cmd.rd_zone_id};

  // Ready only in RUN, and never while reset is held.
  assign run_ready = (state_reg == RUN) && !rst;
  assign wr_fire   = s_cmd.wr_valid && s_data.wvalid && run_ready;
  assign rd_fire   = s_cmd.rd_valid && run_ready;

  assign s_cmd.wr_ready = run_ready;
  assign s_cmd.rd_ready = run_ready;
  assign s_data.wready  = run_ready;
  assign s_data.rvalid  = rvalid_reg;
  assign s_data.rdata   = rdata_reg;
  assign clr_busy       = rst || (state_reg != RUN);

  // State register and clear-sweep counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= CLEAR;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: sweep in CLEAR, serve in RUN, let the pipes retire in DRAIN.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    clear_active = 1'b0;
    case (state_reg)
      CLEAR: begin
        clear_active = 1'b1;
        cnt_next     = cnt_reg + 1'b1;
        if (cnt_reg == ADDR_WIDTH'(DEPTH - 1)) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (clr_req) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Nothing new is accepted here. Once S1 and R1 are empty, whatever sits
        // in S2 retires its write at the end of this very cycle and rdata is
        // launched from R1's last contents, so the sweep can start next cycle
        // without racing any in-flight access.
        if (!s1_reg.valid && !r1_valid_reg) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  // Capture an accepted write command into S1.
  always_comb begin
    s1_next          = '0;
    s1_next.valid    = wr_fire;
    s1_next.addr     = s_cmd.wr_addr;
    s1_next.mask     = s_cmd.wr_mask;
    s1_next.accum_en = s_cmd.accum_en;
    s1_next.data     = s_data.wdata;
  end

  // Carry S1 forward to S2 with the freshly computed words.
  always_comb begin
    s2_next          = s1_reg;
    s2_next.data     = rmw_new;
  end

  // Write/read pipeline registers; reset drops anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_reg       <= '0;
      s2_reg       <= '0;
      r1_valid_reg <= 1'b0;
      r1_addr_reg  <= '0;
      r1_mask_reg  <= '0;
      rvalid_reg   <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      s1_reg       <= s1_next;
      s2_reg       <= s2_next;
      r1_valid_reg <= rd_fire;
      r1_addr_reg  <= s_cmd.rd_addr;
      r1_mask_reg  <= s_cmd.rd_mask;
      rvalid_reg   <= r1_valid_reg;
      rdata_reg    <= r1_valid_reg ? rd_lane : '0;
    end
  end

  // The sweep owns the write port in CLEAR; otherwise S2 writes its address.
  assign bank_waddr = clear_active ? cnt_reg : s2_reg.addr;

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic fwd_rmw;
      logic fwd_host;

      // S2 has not landed in the array yet; bypass it for a matching bank.
      assign fwd_rmw  = s2_reg.valid && s2_reg.mask[gi] && (s2_reg.addr == s1_reg.addr);
      assign fwd_host = s2_reg.valid && s2_reg.mask[gi] && (s2_reg.addr == r1_addr_reg);

      assign rmw_old[gi]  = fwd_rmw ? s2_reg.data[gi] : rmw_rd[gi];
      // Modulo-2^DATA_WIDTH sum; carry out is intentionally discarded.
      assign rmw_new[gi]  = s1_reg.accum_en ? (rmw_old[gi] + s1_reg.data[gi])
                                            : s1_reg.data[gi];

      assign host_val[gi] = fwd_host ? s2_reg.data[gi] : host_rd[gi];
      assign rd_lane[gi]  = r1_mask_reg[gi] ? host_val[gi] : '0;

      assign bank_we[gi]    = clear_active || (s2_reg.valid && s2_reg.mask[gi]);
      assign bank_wdata[gi] = clear_active ? '0 : s2_reg.data[gi];

      accum_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
      ) u_bank (
        .clk       (clk),
        .we        (bank_we[gi]),
        .waddr     (bank_waddr),
        .wdata     (bank_wdata[gi]),
        .rmw_addr  (s1_reg.addr),
        .rmw_data  (rmw_rd[gi]),
        .host_addr (r1_addr_reg),
        .host_data (host_rd[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_accum_zone.sv
// Directed bench for accum_zone: reset sweep, accumulate/overwrite, hazards,
// masking, wrap, ordering, and clear/reset during traffic.
module tb_accum_zone;
  import accum_pkg::*;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  logic clr_req;
  logic clr_busy;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  Accum_Cmd_If  cmd_if ();
  Accum_Data_If data_if ();

  accum_zone dut (
    .clk      (clk),
    .rst      (rst),
    .s_cmd    (cmd_if),
    .s_data   (data_if),
    .clr_req  (clr_req),
    .clr_busy (clr_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic lane_t mk(input logic [63:0] l0, input logic [63:0] l1,
                               input logic [63:0] l2, input logic [63:0] l3);
    lane_t v;
    v[0] = l0;
    v[1] = l1;
    v[2] = l2;
    v[3] = l3;
    return v;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a write for one accepted cycle.
  task automatic do_write(input logic [7:0] a, input logic [3:0] m, input logic acc, input lane_t d);
    cmd_if.wr_valid  = 1'b1;
    data_if.wvalid   = 1'b1;
    cmd_if.wr_addr   = a;
    cmd_if.wr_mask   = m;
    cmd_if.accum_en  = acc;
    data_if.wdata    = d;
    tick();
    cmd_if.wr_valid  = 1'b0;
    data_if.wvalid   = 1'b0;
  endtask

  // Issue a read, check rvalid/rdata timing around it, compare the returned beat.
  // Any write the caller left asserted is accepted in the same cycle.
  task automatic do_read(input string tag, input logic [7:0] a, input logic [3:0] m, input lane_t exp);
    cmd_if.rd_valid = 1'b1;
    cmd_if.rd_addr  = a;
    cmd_if.rd_mask  = m;
    tick();
    cmd_if.rd_valid = 1'b0;
    cmd_if.wr_valid = 1'b0;
    data_if.wvalid  = 1'b0;
    check({tag, "_rvalid_t1"}, data_if.rvalid, 1'b0);
    check({tag, "_rdata_t1"}, data_if.rdata, '0);
    tick();
    check({tag, "_rvalid_t2"}, data_if.rvalid, 1'b1);
    check({tag, "_rdata"}, data_if.rdata, exp);
    tick();
    check({tag, "_rvalid_t3"}, data_if.rvalid, 1'b0);
  endtask

  initial begin
    int bad_ready;
    int bad_busy;
    int waited;

    rst             = 1'b1;
    clr_req         = 1'b0;
    cmd_if.wr_valid = 1'b0;
    cmd_if.accum_en = 1'b0;
    cmd_if.wr_mask  = '0;
    cmd_if.wr_addr  = '0;
    cmd_if.wr_zone_id = '0;
    cmd_if.rd_valid = 1'b0;
    cmd_if.rd_mask  = '0;
    cmd_if.rd_addr  = '0;
    cmd_if.rd_zone_id = '0;
    data_if.wvalid  = 1'b0;
    data_if.wdata   = '0;

    // Reset state
    tick();
    tick();
    check("rst_wr_ready", cmd_if.wr_ready, 1'b0);
    check("rst_rd_ready", cmd_if.rd_ready, 1'b0);
    check("rst_wready", data_if.wready, 1'b0);
    check("rst_rvalid", data_if.rvalid, 1'b0);
    check("rst_rdata", data_if.rdata, '0);
    check("rst_clr_busy", clr_busy, 1'b1);
    rst = 1'b0;

    // 256 cycles of clearing with readies low
    bad_ready = 0;
    bad_busy  = 0;
    for (int i = 0; i < 256; i++) begin
      if (cmd_if.rd_ready || cmd_if.wr_ready || data_if.wready) bad_ready++;
      if (!clr_busy) bad_busy++;
      tick();
    end
    check("clear_ready_low_cycles", bad_ready, 0);
    check("clear_busy_high_cycles", bad_busy, 0);
    check("run_rd_ready", cmd_if.rd_ready, 1'b1);
    check("run_wr_ready", cmd_if.wr_ready, 1'b1);
    check("run_wready", data_if.wready, 1'b1);
    check("run_clr_busy", clr_busy, 1'b0);

    do_read("rd_after_reset", 8'd77, 4'hF, '0);

    // Overwrite then accumulate
    do_write(8'd5, 4'hF, 1'b0, mk(64'd1, 64'd2, 64'd3, 64'd4));
    do_write(8'd5, 4'hF, 1'b1, mk(64'd10, 64'd10, 64'd10, 64'd10));
    do_read("ovw_acc", 8'd5, 4'hF, mk(64'd11, 64'd12, 64'd13, 64'd14));

    // Back-to-back accumulate to one address
    cmd_if.wr_valid = 1'b1;
    data_if.wvalid  = 1'b1;
    cmd_if.wr_addr  = 8'd7;
    cmd_if.wr_mask  = 4'hF;
    cmd_if.accum_en = 1'b1;
    data_if.wdata   = mk(64'd1, 64'd1, 64'd1, 64'd1);
    repeat (4) tick();
    cmd_if.wr_valid = 1'b0;
    data_if.wvalid  = 1'b0;
    do_read("b2b_hazard", 8'd7, 4'hF, mk(64'd4, 64'd4, 64'd4, 64'd4));

    // Masking and wrap-around
    do_write(8'd3, 4'hF, 1'b0, mk(ONES, ONES, ONES, ONES));
    do_write(8'd3, 4'b0101, 1'b1, mk(64'd2, 64'd2, 64'd2, 64'd2));
    do_read("mask_wrap_rm3", 8'd3, 4'b0011, mk(64'd1, ONES, 64'd0, 64'd0));
    do_read("mask_wrap_full", 8'd3, 4'hF, mk(64'd1, ONES, 64'd1, ONES));

    // Ordering: read one cycle after write sees it
    do_write(8'd9, 4'hF, 1'b1, mk(64'd5, 64'd5, 64'd5, 64'd5));
    do_read("order_next", 8'd9, 4'hF, mk(64'd5, 64'd5, 64'd5, 64'd5));

    // Same-cycle write and read: read sees the old value
    cmd_if.wr_valid = 1'b1;
    data_if.wvalid  = 1'b1;
    cmd_if.wr_addr  = 8'd9;
    cmd_if.wr_mask  = 4'hF;
    cmd_if.accum_en = 1'b1;
    data_if.wdata   = mk(64'd3, 64'd3, 64'd3, 64'd3);
    do_read("order_same", 8'd9, 4'hF, mk(64'd5, 64'd5, 64'd5, 64'd5));
    do_read("order_after", 8'd9, 4'hF, mk(64'd8, 64'd8, 64'd8, 64'd8));

    // Half handshakes are not accepted
    cmd_if.wr_valid = 1'b1;
    data_if.wvalid  = 1'b0;
    data_if.wdata   = mk(64'd100, 64'd100, 64'd100, 64'd100);
    tick();
    cmd_if.wr_valid = 1'b0;
    data_if.wvalid  = 1'b1;
    tick();
    data_if.wvalid  = 1'b0;
    do_read("half_handshake", 8'd9, 4'hF, mk(64'd8, 64'd8, 64'd8, 64'd8));

    // Clear while writes stream in
    cmd_if.wr_valid = 1'b1;
    data_if.wvalid  = 1'b1;
    cmd_if.wr_addr  = 8'd20;
    cmd_if.wr_mask  = 4'hF;
    cmd_if.accum_en = 1'b1;
    data_if.wdata   = mk(64'd1, 64'd1, 64'd1, 64'd1);
    repeat (3) tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    check("clr_wr_ready_drop", cmd_if.wr_ready, 1'b0);
    check("clr_rd_ready_drop", cmd_if.rd_ready, 1'b0);
    check("clr_busy_set", clr_busy, 1'b1);
    cmd_if.wr_valid = 1'b0;
    data_if.wvalid  = 1'b0;
    waited = 0;
    while (!cmd_if.rd_ready && waited < 400) begin
      tick();
      waited++;
    end
    check("clr_cycles_to_ready", waited, 258);
    check("clr_busy_done", clr_busy, 1'b0);
    do_read("clr_addr20", 8'd20, 4'hF, '0);
    do_read("clr_addr5", 8'd5, 4'hF, '0);
    do_read("clr_addr3", 8'd3, 4'hF, '0);

    // Reset in the middle of a clear restarts the full sweep
    do_write(8'd40, 4'hF, 1'b0, mk(64'd9, 64'd9, 64'd9, 64'd9));
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    tick();
    check("midclr_rst_busy", clr_busy, 1'b1);
    check("midclr_rst_ready", cmd_if.rd_ready, 1'b0);
    rst = 1'b0;
    waited = 0;
    while (!cmd_if.rd_ready && waited < 400) begin
      tick();
      waited++;
    end
    check("midclr_rst_cycles", waited, 256);
    do_read("midclr_addr40", 8'd40, 4'hF, '0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/accum_zone.md
Name: accum_zone

Overview:
- One accumulator zone: the downstream endpoint behind the accumulator router. One instance per zone; the router gates valids by zone ID, so this block ignores the zone-ID fields.
- Holds NUM_BANKS banks of DEPTH x DATA_WIDTH words.
- Performs masked read-modify-write (accumulate) or overwrite on write commands.
- Returns masked read data with fixed latency; zeroes itself after reset or on request.

Parameters:
- NUM_BANKS, 4, banks per zone (lanes per beat)
- DATA_WIDTH, 64, bits per bank word
- DEPTH, 256, words per bank
- ADDR_WIDTH, 8, address width; DEPTH = 2**ADDR_WIDTH

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_cmd  Accum_Cmd_If.Slave  -  carries the fields listed below
  - wr_valid, wr_ready: write command handshake
  - accum_en: 1 = accumulate, 0 = overwrite
  - wr_mask: NUM_BANKS bits, bank enables for the write
  - wr_addr: ADDR_WIDTH bits
  - rd_valid, rd_ready: read command handshake
  - rd_mask: NUM_BANKS bits, bank enables for the read
  - rd_addr: ADDR_WIDTH bits
  - wr_zone_id, rd_zone_id: unused
- s_data  Accum_Data_If.Slave  -  carries the fields listed below
  - wvalid, wready: write data handshake
  - wdata: NUM_BANKS x DATA_WIDTH
  - rvalid: read data valid
  - rdata: NUM_BANKS x DATA_WIDTH
- clr_req  in  1  single-cycle pulse requesting a full zone clear
- clr_busy  out  1  high while draining or clearing

Behaviour:
- Reset (synchronous, active-high):
  - FSM goes to CLEAR; clear counter = 0.
  - Pipelines are flushed and in-flight writes are dropped. This also applies to reset mid-operation.
  - Output values: wr_ready = wready = rd_ready = 0, rvalid = 0, rdata = 0, clr_busy = 1.
- FSM states:
  - CLEAR: writes zero to address cnt in every bank each cycle. When cnt = DEPTH-1, the zero is written and the FSM goes to RUN the next cycle. Takes DEPTH cycles.
  - RUN: wr_ready = wready = rd_ready = 1, clr_busy = 0. A clr_req goes to DRAIN.
  - DRAIN: all readies = 0 and clr_busy = 1. Waits until the write pipe (S1, S2) and read pipe (R1) are empty, then goes to CLEAR with cnt = 0. At most 2 cycles.
  - clr_req during CLEAR or DRAIN is ignored.
- Write accept: in cycle T when wr_valid & wvalid & wr_ready & wready.
  - wr_valid without wvalid, or the reverse, is not accepted. Nothing is consumed.
- Write pipeline:
  - T+1 (S1): read old[b] = mem[b][addr] for banks with wr_mask[b]=1. Forward from S2 when S2 is valid, same address, and S2 mask bit set.
  - S1 computes new[b] = accum_en ? old[b] + wdata[b] : wdata[b]. The sum is modulo 2^DATA_WIDTH: overflow wraps, no flag.
  - new is registered into S2.
  - T+2 (S2): mem[b][addr] <= new[b] at the end of the cycle, only for masked banks.
  - Unmasked banks are never modified.
  - Accepting back-to-back writes to the same address every cycle must accumulate exactly.
- Read accept: in cycle T when rd_valid & rd_ready.
  - T+1 (R1): reads mem. Forwards the S2 value per bank when S2 is valid, same address, and mask bit set.
  - T+2: rvalid = 1 for exactly one cycle. rdata[b] = value for banks with rd_mask[b]=1, else 0.
  - There is no rdata backpressure.
- Ordering: a read observes every write accepted strictly before it. A write accepted in the same cycle as the read is not observed.
- Simultaneous write and read accept: both proceed; they use independent read ports.
- rvalid = 0 and rdata = 0 in every cycle without a returning read.
- Throughput: one write and one read per cycle in RUN.

Decomposition:
- accum_pkg holds:
  - DATA_WIDTH, NUM_BANKS, DEPTH defaults
  - lane_t (NUM_BANKS x DATA_WIDTH packed)
  - zone_state_e {CLEAR, RUN, DRAIN}
  - write pipe stage struct {valid, addr, mask, accum_en, data}
- Sub-module accum_bank holds one bank:
  - register array
  - two asynchronous read ports (RMW, host)
  - one synchronous write port with enable
  - instantiated NUM_BANKS times by generate

Test Plan:
- Reset, then idle: rd_ready = 0 for 256 cycles and clr_busy = 1; on cycle 257 readies are 1. A read of any address returns 0, rvalid at T+2.
- Overwrite then accumulate: write addr 5, mask 4'b1111, accum_en = 0, wdata {1,2,3,4}. Then addr 5, accum_en = 1, {10,10,10,10}. A read of addr 5 returns {11,12,13,14}.
- Back-to-back hazard: 4 consecutive cycles writing addr 7, accum_en = 1, all lanes 1, starting from 0. The read returns 4 in every lane.
- Masking and wrap:
  - Write addr 3 with lanes all 0xFFFF_FFFF_FFFF_FFFF, then accumulate 2 with mask 4'b0101.
  - Lanes 0 and 2 = 1; lanes 1 and 3 unchanged at all-ones.
  - A read with rd_mask 4'b0011 returns {1, all-ones, 0, 0}.
- Ordering:
  - Write addr 9 (+5) at T, read addr 9 at T+1: returns 5.
  - Write at T with a read in the same cycle T: the read returns the pre-write value.
- Clear mid-traffic:
  - Writes every cycle, clr_req pulsed: readies drop the next cycle and clr_busy = 1.
  - After DRAIN + 256 cycles, all reads return 0.
  - Reset asserted mid-clear restarts the full 256-cycle clear.
